// File: rtl/wb_queue_if.sv
// Write-back queue port bundle: EX offer, register-file write port and two ID lookups.
// The master side drives offers, acks and lookup addresses; the slave side is the queue.
interface wb_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          valid_i;
   logic [4:0]    wd_i;
   logic          wreg_i;
   logic [31:0]   wdata_i;
   logic          ready_o;
   logic          we_o;
   logic [4:0]    waddr_o;
   logic [31:0]   wdata_o;
   logic          wb_ack_i;
   logic [4:0]    raddr1_i;
   logic [4:0]    raddr2_i;
   logic          hit1_o;
   logic          hit2_o;
   logic [31:0]   rdata1_o;
   logic [31:0]   rdata2_o;
   logic [CW-1:0] count_o;

   // Handshakes: an offer completes on a rising edge with valid_i && ready_o;
   // a head write completes on a rising edge with we_o && wb_ack_i.
   modport master (
      output valid_i, wd_i, wreg_i, wdata_i, wb_ack_i, raddr1_i, raddr2_i,
      input  ready_o, we_o, waddr_o, wdata_o, hit1_o, hit2_o, rdata1_o, rdata2_o, count_o
   );

   modport slave (
      input  valid_i, wd_i, wreg_i, wdata_i, wb_ack_i, raddr1_i, raddr2_i,
      output ready_o, we_o, waddr_o, wdata_o, hit1_o, hit2_o, rdata1_o, rdata2_o, count_o
   );
endinterface

// File: rtl/wb_queue.sv
// Circular write-back queue between EX and the register file, with two
// combinational forwarding lookups that return the youngest matching entry.
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   wb_queue_if.slave   q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic ready;
   logic accept;
   logic push;
   logic pop;

   // ready depends only on stored occupancy, so a same-cycle pop never frees a slot.
   assign ready  = (count < CW'(DEPTH));
   assign accept = q.valid_i && ready;
   assign push   = accept && q.wreg_i && (q.wd_i != 5'd0);
   assign pop    = (count != '0) && q.wb_ack_i;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= q.wd_i;
         data_mem[wr_ptr] <= q.wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign q.ready_o = ready;
   assign q.count_o = count;
   assign q.we_o    = (count != '0);
   assign q.waddr_o = (count != '0) ? addr_mem[rd_ptr] : 5'd0;
   assign q.wdata_o = (count != '0) ? data_mem[rd_ptr] : 32'd0;

   logic [AW-1:0] idx;
   logic          hit1;
   logic          hit2;
   logic [31:0]   rdata1;
   logic [31:0]   rdata2;

   // Walk from head (oldest) to tail so later matches overwrite earlier ones.
   always_comb begin
      idx    = '0;
      hit1   = 1'b0;
      hit2   = 1'b0;
      rdata1 = 32'd0;
      rdata2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (CW'(i) < count) begin
            if ((q.raddr1_i != 5'd0) && (addr_mem[idx] == q.raddr1_i)) begin
               hit1   = 1'b1;
               rdata1 = data_mem[idx];
            end
            if ((q.raddr2_i != 5'd0) && (addr_mem[idx] == q.raddr2_i)) begin
               hit2   = 1'b1;
               rdata2 = data_mem[idx];
            end
         end
      end
   end

   assign q.hit1_o   = hit1;
   assign q.hit2_o   = hit2;
   assign q.rdata1_o = rdata1;
   assign q.rdata2_o = rdata2;
endmodule
